data_mem_responder: RTL and testbench

Memory-side responder for the CPU's load/store interface: accepts one word-sized load (LW) or store (SW) request at a time over a valid/ready handshake and services it from an on-chip word RAM. It returns read data or an error flag over a second valid/ready channel. It sits between the CPU's memory-stage request port and data memory, and is the responder for the requests the CPU issues using the LOAD/STORE opcodes and the LW/SW funct3 encodings.

---
 rtl/cpu_control_package.sv | 17 +
 rtl/data_mem_ram.sv | 21 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_package.sv
// Shared CPU control encodings plus the data-memory
// handshake state type used by requester and responder.
package cpu_control_package;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LW = 3'b010;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_t;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word RAM: synchronous write,
// registered read with one cycle of latency.
module data_mem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// LW/SW responder: one request in flight, legality
// check, and registered response toward the CPU.
module data_mem_responder
  import cpu_control_package::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  mem_rsp_state_t state_q, state_d;

  logic        rdy_q;
  logic        vld_q;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic        legal;
  logic [2:0]  f3_exp;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;

  assign f3_exp = req_write ? FUNCT3_SW
                            : FUNCT3_LW;

  assign legal = (req_funct3 == f3_exp)
              && (req_addr[1:0] == 2'b00)
              && (req_addr[31:ADDR_WIDTH] == '0);

  // rdy_q is low during reset even though state is IDLE
  assign accept = req_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_write) begin
            ram_we  = 1'b1;
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            ram_re  = 1'b1;
            state_d = READ;
            err_d   = 1'b0;
          end
        end
      end
      READ: begin
        rdata_d = ram_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      vld_q   <= (state_d == RESP);
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_error = err_q;
  assign rsp_rdata = rdata_q;

  data_mem_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (req_addr[ADDR_WIDTH-1:2]),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency,
// legality, stall hold and reset behaviour.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input string       tag,
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d
  );
    int n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic txn(
    input string       tag,
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d,
    input int          exp_lat,
    input logic        exp_err,
    input logic [31:0] exp_rd
  );
    int lat;
    issue(tag, w, f3, a, d);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(rsp_error),
          32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    drain();
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;

    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_error", 32'(rsp_error), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    tick();
    tick();
    check("rst_ready_hold", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_ready", 32'(req_ready), 32'd1);

    txn("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF,
        1, 0, 32'h0);
    txn("lw10", 0, 3'b010, 32'h10, 32'h0,
        2, 0, 32'hDEADBEEF);
    txn("lw12", 0, 3'b010, 32'h12, 32'h0,
        1, 1, 32'h0);
    txn("lw10b", 0, 3'b010, 32'h10, 32'h0,
        2, 0, 32'hDEADBEEF);
    txn("sw_f3", 1, 3'b001, 32'h10, 32'h12345678,
        1, 1, 32'h0);
    txn("lw10c", 0, 3'b010, 32'h10, 32'h0,
        2, 0, 32'hDEADBEEF);
    txn("lw1000", 0, 3'b010, 32'h1000, 32'h0,
        1, 1, 32'h0);
    txn("sw1010", 1, 3'b010, 32'h1010, 32'h55AA55AA,
        1, 1, 32'h0);
    txn("lw10d", 0, 3'b010, 32'h10, 32'h0,
        2, 0, 32'hDEADBEEF);
    txn("sw7fc", 1, 3'b010, 32'h7FC, 32'hA5A50F0F,
        1, 0, 32'h0);
    txn("sw000", 1, 3'b010, 32'h0, 32'h01234567,
        1, 0, 32'h0);
    txn("lw7fc", 0, 3'b010, 32'h7FC, 32'h0,
        2, 0, 32'hA5A50F0F);
    txn("lw000", 0, 3'b010, 32'h0, 32'h0,
        2, 0, 32'h01234567);

    // response held by a stalled consumer
    rsp_ready = 1'b0;
    issue("stall", 0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_idle", 32'(req_ready), 32'd1);
    check("stall_drop", 32'(rsp_valid), 32'd0);

    // reset while the load sits in READ
    txn("sw20", 1, 3'b010, 32'h20, 32'h0BADF00D,
        1, 0, 32'h0);
    issue("rd_rst", 0, 3'b010, 32'h20, 32'h0);
    rst = 1'b1;
    #1;
    check("rdrst_valid", 32'(rsp_valid), 32'd0);
    check("rdrst_ready", 32'(req_ready), 32'd0);
    tick();
    check("rdrst_hold", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rdrst_rel", 32'(req_ready), 32'd1);
    check("rdrst_rdata", rsp_rdata, 32'h0);
    txn("lw20", 0, 3'b010, 32'h20, 32'h0,
        2, 0, 32'h0BADF00D);

    // reset while a response is pending
    rsp_ready = 1'b0;
    issue("rs_rst", 0, 3'b010, 32'h7FC, 32'h0);
    wait_rsp(lat);
    check("rsrst_pend", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rsrst_valid", 32'(rsp_valid), 32'd0);
    check("rsrst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("rsrst_rel", 32'(req_ready), 32'd1);
    check("rsrst_idle", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
